// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and width helpers for the elastic pipeline stage chain.
// Imported by the slot register and the chain top.
package pipe_stage_chain_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int STAGES_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    // Bits needed to hold a count of 0..n set bits.
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid/data register slot of the stage chain.
// Load wins over clear; the payload is kept when the slot empties.
module pipe_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES slots with valid/ready back-pressure,
// global stall, per-slot flush and a saturating drop counter.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int STAGES = STAGES_DEF,
    parameter  int CNT_W  = CNT_W_DEF,
    localparam int OCC_W  = occ_w(STAGES)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall,
    input  logic [STAGES-1:0] flush_mask,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] src    [STAGES];
    logic [STAGES-1:0] live;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] clear;
    logic [STAGES-1:0] nxt_valid;
    logic [OCC_W-1:0]  nxt_cnt;
    logic [OCC_W-1:0]  drop_num;
    logic [SUM_W-1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_nxt;

    assign live = valid_q & ~flush_mask;

    // A slot is ready when it will be empty or its entry moves on.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready & ~stall;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~stall & (~live[i] | rdy[i+1]);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign load[g] = in_valid & rdy[0];
            assign src[g]  = in_data;
        end else begin : g_body
            assign load[g] = live[g-1] & rdy[g];
            assign src[g]  = data_q[g-1];
        end

        assign clear[g]     = flush_mask[g] | (live[g] & rdy[g+1]);
        assign nxt_valid[g] = load[g] | (valid_q[g] & ~clear[g]);

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .Clk       (Clk),
            .Rst       (Rst),
            .load      (load[g]),
            .clear     (clear[g]),
            .load_data (src[g]),
            .valid     (valid_q[g]),
            .data      (data_q[g])
        );
    end

    always_comb begin
        nxt_cnt  = '0;
        drop_num = '0;
        for (int i = 0; i < STAGES; i++) begin
            nxt_cnt  = nxt_cnt + OCC_W'(nxt_valid[i]);
            drop_num = drop_num + OCC_W'(valid_q[i] & flush_mask[i]);
        end
    end

    always_comb begin
        drop_sum = SUM_W'(drop_count) + SUM_W'(drop_num);
        if (drop_sum > SUM_W'(CNT_MAX)) begin
            drop_nxt = CNT_MAX;
        end else begin
            drop_nxt = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            occupancy  <= '0;
            drop_count <= '0;
        end else begin
            occupancy  <= nxt_cnt;
            drop_count <= drop_nxt;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = live[STAGES-1] & ~stall;
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomized bench for pipe_stage_chain against a slot-occupancy model.
module tb_pipe_stage_chain;

    localparam int S = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        stall;
    logic [3:0]  flush_mask;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  occupancy;
    logic [15:0] drop_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic [2:0]  s_occupancy;
    logic [1:0]  s_drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    bit          mv [S];
    logic [15:0] md [S];
    int          drop_big;
    int          drop_small;
    logic [15:0] got_q [$];

    always #5 Clk = ~Clk;

    pipe_stage_chain #(.DATA_W(16), .STAGES(S), .CNT_W(16)) u_dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stall      (stall),
        .flush_mask (flush_mask),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    pipe_stage_chain #(.DATA_W(16), .STAGES(S), .CNT_W(2)) u_sat (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (s_in_ready),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .out_ready  (out_ready),
        .stall      (stall),
        .flush_mask (flush_mask),
        .occupancy  (s_occupancy),
        .drop_count (s_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance it.
    task automatic cyc(input bit r, input bit iv, input logic [15:0] d,
                       input bit ordy, input bit st, input logic [3:0] fm);
        bit          alive [S];
        bit          nv [S];
        logic [15:0] nd [S];
        bit          vac;
        int          nk;
        int          kill;
        @(negedge Clk);
        Rst = r; in_valid = iv; in_data = d;
        out_ready = ordy; stall = st; flush_mask = fm;
        #1;
        nk = 0;
        kill = 0;
        for (int i = 0; i < S; i++) begin
            nk += int'(mv[i]);
            alive[i] = mv[i] && !fm[i];
            kill += int'(mv[i] && fm[i]);
            nv[i] = alive[i];
            nd[i] = md[i];
        end
        check("occupancy", 32'(occupancy), 32'(nk));
        check("drop_count", 32'(drop_count), 32'(drop_big));
        check("drop_sat", 32'(s_drop_count), 32'(drop_small));
        check("sat_occ", 32'(s_occupancy), 32'(nk));
        // Walk from the consumer end: an entry advances into a vacancy.
        vac = ordy;
        if (!st) begin
            for (int i = S - 1; i >= 0; i--) begin
                if (alive[i] && vac) begin
                    if (i < S - 1) begin
                        nv[i+1] = 1'b1;
                        nd[i+1] = md[i];
                    end
                    nv[i] = 1'b0;
                    vac = 1'b1;
                end else begin
                    vac = !alive[i];
                end
            end
        end
        check("in_ready", 32'(in_ready), 32'(!st && vac));
        check("out_valid", 32'(out_valid), 32'(!st && alive[S-1]));
        check("sat_in_ready", 32'(s_in_ready), 32'(!st && vac));
        if (!st && alive[S-1]) begin
            check("out_data", 32'(out_data), 32'(md[S-1]));
            check("sat_out_data", 32'(s_out_data), 32'(md[S-1]));
        end
        if (!st && vac && iv) begin
            nv[0] = 1'b1;
            nd[0] = d;
        end
        if (r) begin
            for (int i = 0; i < S; i++) begin
                mv[i] = 1'b0;
                md[i] = '0;
            end
            drop_big = 0;
            drop_small = 0;
        end else begin
            mv = nv;
            md = nd;
            drop_big = (drop_big + kill > 65535) ? 65535 : drop_big + kill;
            drop_small = (drop_small + kill > 3) ? 3 : drop_small + kill;
        end
    endtask

    // Drain with out_ready=1, collecting delivered payloads.
    task automatic drain(input int n);
        got_q.delete();
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'b0);
            if (out_valid) got_q.push_back(out_data);
        end
    endtask

    initial begin
        int first_out;
        logic [15:0] first_data;
        Rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush_mask = '0;
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        drop_big = 0;
        drop_small = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'b0);

        // Streaming: latency of 4 edges, full throughput.
        first_out = -1;
        first_data = '0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 16'(k), 1'b1, 1'b0, 4'b0);
            if (out_valid && first_out < 0) begin
                first_out = k;
                first_data = out_data;
            end
        end
        check("stream_latency", 32'(first_out), 32'd5);
        check("stream_first", 32'(first_data), 32'h0001);
        check("stream_occ", 32'(occupancy), 32'd4);
        drain(6);

        // Back-pressure then release without bubbles.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'(16'hA0 + k), 1'b0, 1'b0, 4'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 16'hAA, 1'b0, 1'b0, 4'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold", 32'(out_data), 32'h00A0);
        drain(4);
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int k = 0; k < got_q.size(); k++) check("bp_order", 32'(got_q[k]), 32'(16'hA0 + k));

        // Flush of the two youngest entries.
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'(16'hB0 + k), 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0011);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0);
        check("flush_occ", 32'(occupancy), 32'd2);
        check("flush_drop", 32'(drop_count), 32'd2);
        drain(4);
        check("flush_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("flush_b0", 32'(got_q[0]), 32'h00B0);
            check("flush_b1", 32'(got_q[1]), 32'h00B1);
        end

        // Three more drops saturate the 2-bit counter.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 16'(16'hE0 + k), 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1111);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0);
        check("sat_big", 32'(drop_count), 32'd5);
        check("sat_small", 32'(s_drop_count), 32'd3);

        // Stall holds contents, then plain delivery.
        cyc(1'b0, 1'b1, 16'hC0, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b1, 16'hC1, 1'b0, 1'b0, 4'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 16'hCC, 1'b1, 1'b1, 4'b0);
        drain(5);
        check("stall_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("stall_c0", 32'(got_q[0]), 32'h00C0);
            check("stall_c1", 32'(got_q[1]), 32'h00C1);
        end

        // Stall with flush of the output slot.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'(16'hD0 + k), 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 4'b1000);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'b0);
        check("stflush_occ", 32'(occupancy), 32'd3);
        check("stflush_drop", 32'(drop_count), 32'd6);
        drain(5);

        // Reset mid-stream.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 16'(16'hF0 + k), 1'b0, 1'b0, 4'b0);
        cyc(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0);
        check("mrst_occ", 32'(occupancy), 32'd0);
        check("mrst_drop", 32'(drop_count), 32'd0);
        check("mrst_sat_drop", 32'(s_drop_count), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);

        // Random traffic in a few mixes of pressure, stalls and flushes.
        for (int ph = 0; ph < 4; ph++) begin
            int piv, pord, pst, pfl;
            piv  = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 80 : 70;
            pord = (ph == 0) ? 90 : (ph == 1) ? 80 : (ph == 2) ? 30 : 60;
            pst  = (ph == 3) ? 25 : 8;
            pfl  = (ph == 2) ? 15 : 5;
            for (int k = 0; k < 500; k++) begin
                logic [3:0] fm;
                for (int b = 0; b < S; b++) fm[b] = ($urandom_range(0, 99) < pfl);
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 99) < piv,
                    16'($urandom),
                    $urandom_range(0, 99) < pord,
                    $urandom_range(0, 99) < pst,
                    fm);
            end
        end
        drain(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
